// File: rtl/mem_wb_stage_reg.sv
// mem_wb_stage_reg
// MEM/WB pipeline register with memory-wait handshake.
// Captures the MEM stage results for the WB stage. While a cache/SRAM
// access is outstanding it raises freeze to hold the upstream pipeline
// registers and injects bubbles into WB. An access that stays frozen for
// TIMEOUT cycles is abandoned on the following not-ready cycle, and the
// sticky mem_timeout flag is set. Two saturating performance counters
// track frozen cycles and completed accesses.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   wb_en_in       write-back enable from MEM
//   mem_r_en_in    load in MEM
//   mem_w_en_in    store in MEM
//   alu_result_in  ALU result / address from MEM
//   mem_data_in    memory read data from cache
//   dest_in        destination register
//   mem_ready      combined cache/SRAM ready
//   wb_en          registered write-back enable
//   mem_r_en       registered load flag (WB mux select)
//   alu_result     registered ALU result
//   mem_data       registered memory read data
//   dest           registered destination
//   freeze         combinational hold for upstream registers
//   mem_timeout    sticky: at least one access was abandoned
//   stall_cycles   saturating count of cycles with freeze=1
//   mem_accesses   saturating count of completed accesses

module mem_wb_stage_reg #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_en_in,
    input  logic             mem_r_en_in,
    input  logic             mem_w_en_in,
    input  logic [31:0]      alu_result_in,
    input  logic [31:0]      mem_data_in,
    input  logic [3:0]       dest_in,
    input  logic             mem_ready,
    output logic             wb_en,
    output logic             mem_r_en,
    output logic [31:0]      alu_result,
    output logic [31:0]      mem_data,
    output logic [3:0]       dest,
    output logic             freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] mem_accesses
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] TMO_VAL = WCW'(TIMEOUT);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic           access;
    logic           tmo_hit;
    logic           acc_done;
    logic           wait_exit;

    assign access    = mem_r_en_in | mem_w_en_in;
    assign tmo_hit   = (state == WAIT) && (wait_cnt == TMO_VAL) && !mem_ready;
    assign acc_done  = access & mem_ready;
    // WAIT is left on completion, on abandon, or if the access vanishes
    // (protocol violation, but the FSM must never lock up).
    assign wait_exit = (state == WAIT) && (!access || mem_ready || tmo_hit);

    // Gated by rst so freeze drops the moment reset is asserted.
    assign freeze = rst & access & ~mem_ready & ~tmo_hit;

    // Wait-handshake FSM and the per-access frozen-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (access && !mem_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_exit) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (wait_exit) begin
                wait_cnt <= '0;
            end else if (freeze && (wait_cnt != TMO_VAL)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Pipeline register: bubble while frozen or on abandon, else capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en       <= 1'b0;
            mem_r_en    <= 1'b0;
            alu_result  <= '0;
            mem_data    <= '0;
            dest        <= '0;
            mem_timeout <= 1'b0;
        end else if (freeze) begin
            wb_en    <= 1'b0;
            mem_r_en <= 1'b0;
        end else if (tmo_hit) begin
            wb_en       <= 1'b0;
            mem_r_en    <= 1'b0;
            mem_timeout <= 1'b1;
        end else begin
            wb_en      <= wb_en_in;
            mem_r_en   <= mem_r_en_in;
            alu_result <= alu_result_in;
            mem_data   <= mem_data_in;
            dest       <= dest_in;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            mem_accesses <= '0;
        end else begin
            if (freeze && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (acc_done && (mem_accesses != '1)) begin
                mem_accesses <= mem_accesses + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// tb_mem_wb_stage_reg
// Directed bench for mem_wb_stage_reg with TIMEOUT=4 and CNT_W=4 so that
// the timeout boundary and counter saturation are reachable quickly.
// Inputs change 1 time unit after a rising edge, freeze is sampled 1 unit
// later, registered outputs are sampled 1 unit after the following edge.

module tb_mem_wb_stage_reg;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    logic             clk;
    logic             rst;
    logic             wb_en_in;
    logic             mem_r_en_in;
    logic             mem_w_en_in;
    logic [31:0]      alu_result_in;
    logic [31:0]      mem_data_in;
    logic [3:0]       dest_in;
    logic             mem_ready;
    logic             wb_en;
    logic             mem_r_en;
    logic [31:0]      alu_result;
    logic [31:0]      mem_data;
    logic [3:0]       dest;
    logic             freeze;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] mem_accesses;

    int errors = 0;
    int checks = 0;

    mem_wb_stage_reg #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_en_in     (wb_en_in),
        .mem_r_en_in  (mem_r_en_in),
        .mem_w_en_in  (mem_w_en_in),
        .alu_result_in(alu_result_in),
        .mem_data_in  (mem_data_in),
        .dest_in      (dest_in),
        .mem_ready    (mem_ready),
        .wb_en        (wb_en),
        .mem_r_en     (mem_r_en),
        .alu_result   (alu_result),
        .mem_data     (mem_data),
        .dest         (dest),
        .freeze       (freeze),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles),
        .mem_accesses (mem_accesses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic wb, input logic rd, input logic wr,
                                  input logic [31:0] alu, input logic [31:0] data,
                                  input logic [3:0] dst, input logic rdy);
        wb_en_in      = wb;
        mem_r_en_in   = rd;
        mem_w_en_in   = wr;
        alu_result_in = alu;
        mem_data_in   = data;
        dest_in       = dst;
        mem_ready     = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Absolute guard so the run always ends.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        #2;
        check_output("rst_wb_en", 32'(wb_en), 32'h0);
        check_output("rst_alu", alu_result, 32'h0);
        check_output("rst_mem_data", mem_data, 32'h0);
        check_output("rst_dest", 32'(dest), 32'h0);
        check_output("rst_timeout", 32'(mem_timeout), 32'h0);
        check_output("rst_stall", 32'(stall_cycles), 32'h0);
        check_output("rst_acc", 32'(mem_accesses), 32'h0);
        #6 rst = 1'b1;
        tick();

        // ALU op: one-cycle latency, no freeze.
        apply_stimulus(1, 0, 0, 32'h10, 32'h0, 4'd3, 0);
        #1 check_output("alu_freeze", 32'(freeze), 32'h0);
        tick();
        check_output("alu_wb_en", 32'(wb_en), 32'h1);
        check_output("alu_result", alu_result, 32'h10);
        check_output("alu_dest", 32'(dest), 32'h3);

        // Load hit: ready in the same cycle.
        apply_stimulus(1, 1, 0, 32'h100, 32'hDEADBEEF, 4'd5, 1);
        #1 check_output("hit_freeze", 32'(freeze), 32'h0);
        tick();
        check_output("hit_mem_r_en", 32'(mem_r_en), 32'h1);
        check_output("hit_mem_data", mem_data, 32'hDEADBEEF);
        check_output("hit_stall", 32'(stall_cycles), 32'h0);
        check_output("hit_acc", 32'(mem_accesses), 32'h1);

        // Load miss: 3 not-ready cycles, then ready.
        apply_stimulus(1, 1, 0, 32'h200, 32'h0, 4'd6, 0);
        for (int i = 0; i < 3; i++) begin
            #1 check_output("miss_freeze", 32'(freeze), 32'h1);
            tick();
            check_output("miss_wb_en", 32'(wb_en), 32'h0);
            check_output("miss_alu_hold", alu_result, 32'h100);
        end
        apply_stimulus(1, 1, 0, 32'h200, 32'h12345678, 4'd6, 1);
        #1 check_output("miss_rdy_freeze", 32'(freeze), 32'h0);
        tick();
        check_output("miss_mem_data", mem_data, 32'h12345678);
        check_output("miss_wb_en_cap", 32'(wb_en), 32'h1);
        check_output("miss_dest", 32'(dest), 32'h6);
        check_output("miss_stall", 32'(stall_cycles), 32'h3);
        check_output("miss_acc", 32'(mem_accesses), 32'h2);

        // Timeout: 4 frozen cycles, abandoned on the 5th.
        apply_stimulus(1, 1, 0, 32'h300, 32'h0, 4'd7, 0);
        for (int i = 0; i < TIMEOUT; i++) begin
            #1 check_output("tmo_freeze", 32'(freeze), 32'h1);
            tick();
            check_output("tmo_wb_en", 32'(wb_en), 32'h0);
        end
        #1 check_output("tmo_hit_freeze", 32'(freeze), 32'h0);
        tick();
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'd0, 0);
        check_output("tmo_flag", 32'(mem_timeout), 32'h1);
        check_output("tmo_wb_en_after", 32'(wb_en), 32'h0);
        check_output("tmo_dest_hold", 32'(dest), 32'h6);
        check_output("tmo_stall", 32'(stall_cycles), 32'h7);
        check_output("tmo_acc", 32'(mem_accesses), 32'h2);

        // Sticky flag across normal traffic.
        apply_stimulus(1, 0, 0, 32'h44, 32'h0, 4'd2, 0);
        tick();
        check_output("post_alu_wb_en", 32'(wb_en), 32'h1);
        check_output("post_alu_result", alu_result, 32'h44);
        apply_stimulus(1, 1, 0, 32'h48, 32'h55, 4'd2, 1);
        tick();
        check_output("post_load_data", mem_data, 32'h55);
        check_output("post_load_acc", 32'(mem_accesses), 32'h3);
        check_output("post_tmo_sticky", 32'(mem_timeout), 32'h1);

        // Async reset between edges clears everything.
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'd0, 0);
        rst = 1'b0;
        #1;
        check_output("rst2_timeout", 32'(mem_timeout), 32'h0);
        check_output("rst2_acc", 32'(mem_accesses), 32'h0);
        rst = 1'b1;
        tick();

        // Boundary: ready rises exactly on the would-be timeout cycle.
        apply_stimulus(1, 1, 0, 32'h500, 32'h0, 4'd9, 0);
        for (int i = 0; i < TIMEOUT; i++) begin
            #1 check_output("bnd_freeze", 32'(freeze), 32'h1);
            tick();
        end
        apply_stimulus(1, 1, 0, 32'h500, 32'hCAFEF00D, 4'd9, 1);
        #1 check_output("bnd_rdy_freeze", 32'(freeze), 32'h0);
        tick();
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'd0, 0);
        check_output("bnd_mem_data", mem_data, 32'hCAFEF00D);
        check_output("bnd_wb_en", 32'(wb_en), 32'h1);
        check_output("bnd_timeout", 32'(mem_timeout), 32'h0);
        check_output("bnd_stall", 32'(stall_cycles), 32'h4);
        check_output("bnd_acc", 32'(mem_accesses), 32'h1);
        tick();

        // Async reset during cycle 3 of a stall.
        apply_stimulus(1, 1, 0, 32'h900, 32'h0, 4'd4, 0);
        for (int i = 0; i < 2; i++) begin
            #1 check_output("mid_freeze", 32'(freeze), 32'h1);
            tick();
        end
        #1 check_output("mid_freeze_c3", 32'(freeze), 32'h1);
        rst = 1'b0;
        #1;
        check_output("mid_rst_freeze", 32'(freeze), 32'h0);
        check_output("mid_rst_wb_en", 32'(wb_en), 32'h0);
        check_output("mid_rst_stall", 32'(stall_cycles), 32'h0);
        check_output("mid_rst_data", mem_data, 32'h0);
        rst = 1'b1;
        #1 check_output("mid_rel_freeze", 32'(freeze), 32'h1);
        tick();
        // A stale wait_cnt would abandon the access inside this loop.
        for (int i = 0; i < 3; i++) begin
            #1 check_output("mid_refreeze", 32'(freeze), 32'h1);
            tick();
        end
        apply_stimulus(1, 1, 0, 32'h900, 32'hA5A5A5A5, 4'd4, 1);
        tick();
        check_output("mid_mem_data", mem_data, 32'hA5A5A5A5);
        check_output("mid_wb_en", 32'(wb_en), 32'h1);
        check_output("mid_stall", 32'(stall_cycles), 32'h4);
        check_output("mid_timeout", 32'(mem_timeout), 32'h0);

        // Store: same handshake, wb_en follows wb_en_in.
        apply_stimulus(0, 0, 1, 32'h600, 32'h0, 4'd8, 0);
        #1 check_output("st_freeze", 32'(freeze), 32'h1);
        tick();
        check_output("st_wb_en_frozen", 32'(wb_en), 32'h0);
        apply_stimulus(0, 0, 1, 32'h600, 32'h0, 4'd8, 1);
        tick();
        check_output("st_wb_en", 32'(wb_en), 32'h0);
        check_output("st_mem_r_en", 32'(mem_r_en), 32'h0);
        check_output("st_alu", alu_result, 32'h600);
        check_output("st_acc", 32'(mem_accesses), 32'h2);
        check_output("st_stall", 32'(stall_cycles), 32'h5);

        // mem_ready without an access is ignored.
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'd0, 1);
        #1 check_output("idle_rdy_freeze", 32'(freeze), 32'h0);
        tick();
        check_output("idle_rdy_acc", 32'(mem_accesses), 32'h2);

        // Three back-to-back abandons push stall_cycles past 15.
        apply_stimulus(1, 1, 0, 32'h700, 32'h0, 4'd1, 0);
        repeat (15) tick();
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'd0, 0);
        check_output("sat_stall", 32'(stall_cycles), 32'hF);
        check_output("sat_tmo_flag", 32'(mem_timeout), 32'h1);

        // Fourteen load hits push mem_accesses past 15.
        apply_stimulus(1, 1, 0, 32'h800, 32'h11, 4'd2, 1);
        repeat (14) tick();
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'd0, 0);
        check_output("sat_acc", 32'(mem_accesses), 32'hF);
        check_output("sat_stall_hold", 32'(stall_cycles), 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
